// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: loader and receiver state
// encodings, the frame header byte and the byte-within-word index width.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] BOOT_HDR   = 8'hA5;
    localparam int         BYTE_IDX_W = 2;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port and boot status bundle between the loader (master)
// and the memory / core-reset logic it feeds (slave).
interface uart_boot_loader_if #(
    parameter int ADDR_W = 8
);

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              boot_done;
    logic              boot_err;
    logic [ADDR_W:0]   word_cnt;

    modport master (
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_hold,
        output boot_done,
        output boot_err,
        output word_cnt
    );

    modport slave (
        input imem_we,
        input imem_addr,
        input imem_wdata,
        input core_hold,
        input boot_done,
        input boot_err,
        input word_cnt
    );

endinterface

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection, centre sampling,
// and single-cycle byte_valid / frame_err pulses.
module uart_boot_loader_rx
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

    rx_state_t        state;
    logic [1:0]       sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    // Idle detection is edge based so a line held low after a bad stop bit
    // cannot retrigger a new frame until it has returned high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RX_IDLE;
            sync       <= 2'b11;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], uart_rx};
            rx_prev    <= sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync[1]) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_W'(HALF_BIT - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        rx_byte <= {sync[1], rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt        <= '0;
                        state      <= RX_IDLE;
                        byte_valid <= sync[1];
                        frame_err  <= !sync[1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5/len/data/checksum image, writes it into instruction
// memory and holds the core in reset until it verifies. Option macro: BOOT_TIMEOUT_EN.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
`ifdef BOOT_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1_000_000,
`endif
    parameter int ADDR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    uart_boot_loader_if.master    bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = ADDR_W + 1;

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  frame_err;
    boot_state_t           state;
    logic [CNT_W-1:0]      len;
    logic [23:0]           word_buf;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [7:0]            sum;

    uart_boot_loader_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // A length byte of zero stands for a full memory image.
    function automatic logic [CNT_W-1:0] decode_len(input logic [7:0] n);
        return (n == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(n);
    endfunction

`ifdef BOOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            len            <= '0;
            word_buf       <= '0;
            byte_idx       <= '0;
            sum            <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.core_hold  <= 1'b1;
            bus.boot_done  <= 1'b0;
            bus.boot_err   <= 1'b0;
            bus.word_cnt   <= '0;
`ifdef BOOT_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (byte_valid && rx_byte == BOOT_HDR) begin
                        state         <= LEN;
                        bus.core_hold <= 1'b1;
                        bus.boot_done <= 1'b0;
                        bus.boot_err  <= 1'b0;
                        bus.word_cnt  <= '0;
                        sum           <= '0;
                        byte_idx      <= '0;
                    end
                end
                LEN: begin
                    if (frame_err) begin
                        state        <= ERR;
                        bus.boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        len   <= decode_len(rx_byte);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (frame_err) begin
                        state        <= ERR;
                        bus.boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        sum <= sum + rx_byte;
                        if (byte_idx == '1) begin
                            // Last byte of the word: strobe the write and advance.
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= bus.word_cnt[ADDR_W-1:0];
                            bus.imem_wdata <= {rx_byte, word_buf};
                            bus.word_cnt   <= bus.word_cnt + 1'b1;
                            byte_idx       <= '0;
                            if (bus.word_cnt + 1'b1 == len) begin
                                state <= CSUM;
                            end
                        end else begin
                            case (byte_idx)
                                2'd0:    word_buf[7:0]   <= rx_byte;
                                2'd1:    word_buf[15:8]  <= rx_byte;
                                default: word_buf[23:16] <= rx_byte;
                            endcase
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (frame_err) begin
                        state        <= ERR;
                        bus.boot_err <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_byte == sum) begin
                            state         <= DONE;
                            bus.boot_done <= 1'b1;
                            bus.core_hold <= 1'b0;
                        end else begin
                            state        <= ERR;
                            bus.boot_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef BOOT_TIMEOUT_EN
            // Placed after the case so an expiry overrides any same-cycle transition.
            if (state == LEN || state == DATA || state == CSUM) begin
                if (byte_valid) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt       <= '0;
                    state         <= ERR;
                    bus.boot_err  <= 1'b1;
                    bus.core_hold <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frames built from the image format, expected writes queued
// on issue and checked by an independent write monitor; status checked after each frame.
module tb_uart_boot_loader;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD        = 100_000;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;
    localparam int ADDR_W      = 8;
`ifdef BOOT_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 3000;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_write_t;

    logic clk;
    logic rst;
    logic uart_rx;

    exp_write_t  exp_q[$];
    logic [31:0] next_words[$];
    int          checks   = 0;
    int          failures = 0;

    uart_boot_loader_if #(.ADDR_W(ADDR_W)) bif ();

    uart_boot_loader #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
`ifdef BOOT_TIMEOUT_EN
        .TIMEOUT_CYC(TIMEOUT_CYC),
`endif
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .uart_rx(uart_rx),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst && bif.imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write",
                         bif.imem_addr, bif.imem_wdata);
            end else begin
                exp_write_t e;
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(bif.imem_addr), 32'(e.addr));
                checkOutput("write_data", bif.imem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_bad);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = ~stop_bad;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_junk(input int count);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic check_status(input string tag, input bit done, input bit err, input int cnt);
        checkOutput({tag, ".boot_done"}, 32'(bif.boot_done), 32'(done));
        checkOutput({tag, ".boot_err"}, 32'(bif.boot_err), 32'(err));
        checkOutput({tag, ".core_hold"}, 32'(bif.core_hold), 32'(!done));
        checkOutput({tag, ".word_cnt"}, 32'(bif.word_cnt), 32'(cnt));
        checkOutput({tag, ".pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        checkOutput({tag, ".core_hold"}, 32'(bif.core_hold), 32'd1);
        checkOutput({tag, ".boot_done"}, 32'(bif.boot_done), 32'd0);
        checkOutput({tag, ".boot_err"}, 32'(bif.boot_err), 32'd0);
        checkOutput({tag, ".imem_we"}, 32'(bif.imem_we), 32'd0);
        checkOutput({tag, ".word_cnt"}, 32'(bif.word_cnt), 32'd0);
        checkOutput({tag, ".imem_addr"}, 32'(bif.imem_addr), 32'd0);
        checkOutput({tag, ".imem_wdata"}, bif.imem_wdata, 32'd0);
    endtask

    // One load attempt; err_at is the data byte index sent with a bad stop bit (-1 = none).
    task automatic applyStimulus(input string tag, input int len_byte, input bit bad_csum, input int err_at);
        int          n;
        int          sent_words;
        int          complete;
        bit          done;
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] words[$];
        n          = (len_byte == 0) ? (1 << ADDR_W) : len_byte;
        sent_words = (err_at < 0) ? n : err_at / 4 + 1;
        complete   = (err_at < 0) ? n : err_at / 4;
        sum        = 8'd0;
        for (int i = 0; i < sent_words; i++) begin
            w = (next_words.size() > 0) ? next_words.pop_front() : $urandom;
            words.push_back(w);
            if (i < complete) exp_q.push_back('{addr: ADDR_W'(i), data: w});
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'(len_byte), 1'b0);
        for (int k = 0; k < 4 * sent_words; k++) begin
            w = words[k / 4];
            b = w[8 * (k % 4) +: 8];
            if (k == err_at) begin
                send_byte(b, 1'b1);
                break;
            end
            send_byte(b, 1'b0);
            sum = sum + b;
        end
        if (err_at < 0) send_byte(bad_csum ? sum + 8'd1 : sum, 1'b0);
        repeat (CPB) @(negedge clk);
        done = (err_at < 0) && !bad_csum;
        check_status(tag, done, !done, complete);
    endtask

    initial begin
        rst     = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        next_words = '{32'h0000_0013, 32'h0010_0093};
        applyStimulus("good", 2, 1'b0, -1);

        next_words = '{32'h0000_0013, 32'h0010_0093};
        applyStimulus("bad_csum", 2, 1'b1, -1);

        next_words = '{32'h0000_0013, 32'h0010_0093};
        applyStimulus("recover", 2, 1'b0, -1);

        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b1);
        next_words = '{32'h0000_0013, 32'h0010_0093};
        applyStimulus("junk_lead", 2, 1'b0, -1);

        next_words = '{32'h0000_0013, 32'h0010_0093};
        applyStimulus("stop_err", 2, 1'b0, 1);

        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus("glitch", 3, 1'b0, -1);

        applyStimulus("len_zero", 0, 1'b0, 13);

        for (int f = 0; f < 8; f++) begin
            int n;
            int e;
            bit bad;
            n   = $urandom_range(1, 4);
            bad = ($urandom_range(0, 3) == 0);
            e   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * n - 1)) : -1;
            send_junk($urandom_range(0, 2));
            applyStimulus($sformatf("rand%0d", f), n, bad, e);
        end

`ifdef BOOT_TIMEOUT_EN
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (TIMEOUT_CYC + 200) @(negedge clk);
        check_status("timeout", 1'b0, 1'b1, 0);
`endif

        next_words = '{32'hDEAD_BEEF, 32'h1234_5678};
        applyStimulus("pre_reset", 2, 1'b0, -1);
        exp_q.push_back('{addr: '0, data: 32'hCAFE_F00D});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("mid_reset.pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
